// File: rtl/snoop_state_machine_if.sv
// Bus-side signal bundle for snoop_state_machine (requestor M1 and snooper M2 ports).
// protocol_err exists only when SNOOP_PROTOCOL_CHECK_EN is defined.
interface snoop_state_machine_if #(
    parameter int DATA_W = 8,
    parameter int PROC_W = 2
);
    logic              m1_active;
    logic [2:0]        cpu_action;
    logic [1:0]        m1_state_in;
    logic [PROC_W-1:0] m1_proc_in;
    logic              m1_writeback;
    logic [1:0]        m1_state_out;
    logic [2:0]        bus_msg_out;
    logic [PROC_W-1:0] m1_proc_out;

    logic              m2_active;
    logic              m2_cache_hit;
    logic [1:0]        m2_state_in;
    logic [PROC_W-1:0] m2_proc_in;
    logic [2:0]        bus_msg_in;
    logic [DATA_W-1:0] m2_data_in;
    logic              m2_writeback;
    logic              abort_mem_access;
    logic              m2_hit;
    logic [1:0]        m2_state_out;
    logic [PROC_W-1:0] m2_proc_out;
    logic [DATA_W-1:0] m2_data_out;
`ifdef SNOOP_PROTOCOL_CHECK_EN
    logic              protocol_err;
`endif

    modport master (
        output m1_active, cpu_action, m1_state_in, m1_proc_in,
        input  m1_writeback, m1_state_out, bus_msg_out, m1_proc_out,
        output m2_active, m2_cache_hit, m2_state_in, m2_proc_in, bus_msg_in, m2_data_in,
        input  m2_writeback, abort_mem_access, m2_hit, m2_state_out, m2_proc_out, m2_data_out
`ifdef SNOOP_PROTOCOL_CHECK_EN
        , input protocol_err
`endif
    );

    modport slave (
        input  m1_active, cpu_action, m1_state_in, m1_proc_in,
        output m1_writeback, m1_state_out, bus_msg_out, m1_proc_out,
        input  m2_active, m2_cache_hit, m2_state_in, m2_proc_in, bus_msg_in, m2_data_in,
        output m2_writeback, abort_mem_access, m2_hit, m2_state_out, m2_proc_out, m2_data_out
`ifdef SNOOP_PROTOCOL_CHECK_EN
        , output protocol_err
`endif
    );
endinterface

// File: rtl/snoop_state_machine.sv
// MSI coherence core for one block slot: requestor engine (M1) and snooper engine (M2), 1-cycle registered.
// Optional SNOOP_PROTOCOL_CHECK_EN adds a registered protocol_err pulse.
module snoop_state_machine #(
    parameter int DATA_W = 8,
    parameter int PROC_W = 2
) (
    input logic                   clock,
    input logic                   reset,
    snoop_state_machine_if.slave  sif
);
    typedef enum logic [1:0] {
        BLK_I   = 2'd0,
        BLK_S   = 2'd1,
        BLK_M   = 2'd2,
        BLK_RSV = 2'd3
    } blk_state_t;

    typedef enum logic [2:0] {
        MSG_NONE    = 3'd0,
        MSG_RD_MISS = 3'd1,
        MSG_WR_MISS = 3'd2,
        MSG_INV     = 3'd3
    } bus_msg_t;

    localparam logic [2:0] ACT_RD_HIT  = 3'b001;
    localparam logic [2:0] ACT_RD_MISS = 3'b010;
    localparam logic [2:0] ACT_WR_HIT  = 3'b011;
    localparam logic [2:0] ACT_WR_MISS = 3'b100;

    blk_state_t        m1_state_q, m1_state_d, m1_cur;
    bus_msg_t          m1_bus_q, m1_bus_d;
    logic              m1_wb_q, m1_wb_d;
    logic [PROC_W-1:0] m1_proc_q, m1_proc_d;
    logic [2:0]        m1_act;

    blk_state_t        m2_state_q, m2_state_d, m2_cur;
    logic              m2_wb_q, m2_wb_d;
    logic              m2_abort_q, m2_abort_d;
    logic              m2_hit_q, m2_hit_d;
    logic [PROC_W-1:0] m2_proc_q, m2_proc_d;
    logic [DATA_W-1:0] m2_data_q, m2_data_d;

    // Requestor: hits on an Invalid block are promoted to misses before the table lookup.
    always_comb begin
        m1_state_d = m1_state_q;
        m1_bus_d   = MSG_NONE;
        m1_wb_d    = 1'b0;
        m1_proc_d  = m1_proc_q;
        m1_cur     = (sif.m1_state_in == BLK_RSV) ? BLK_I : blk_state_t'(sif.m1_state_in);
        m1_act     = sif.cpu_action;
        if (m1_cur == BLK_I && m1_act == ACT_RD_HIT) m1_act = ACT_RD_MISS;
        if (m1_cur == BLK_I && m1_act == ACT_WR_HIT) m1_act = ACT_WR_MISS;
        if (sif.m1_active) begin
            m1_proc_d  = sif.m1_proc_in;
            m1_state_d = m1_cur;
            case (m1_act)
                ACT_RD_MISS: begin
                    m1_state_d = BLK_S;
                    m1_bus_d   = MSG_RD_MISS;
                    m1_wb_d    = (m1_cur == BLK_M);
                end
                ACT_WR_HIT: begin
                    m1_state_d = BLK_M;
                    m1_bus_d   = (m1_cur == BLK_S) ? MSG_INV : MSG_NONE;
                end
                ACT_WR_MISS: begin
                    m1_state_d = BLK_M;
                    m1_bus_d   = MSG_WR_MISS;
                    m1_wb_d    = (m1_cur == BLK_M);
                end
                default: ;
            endcase
        end
    end

    // Snooper: only a Modified copy supplies data and cancels the memory read.
    always_comb begin
        m2_state_d = m2_state_q;
        m2_wb_d    = 1'b0;
        m2_abort_d = 1'b0;
        m2_hit_d   = 1'b0;
        m2_proc_d  = m2_proc_q;
        m2_data_d  = m2_data_q;
        m2_cur     = (sif.m2_state_in == BLK_RSV) ? BLK_I : blk_state_t'(sif.m2_state_in);
        if (sif.m2_active) begin
            m2_proc_d  = sif.m2_proc_in;
            m2_state_d = m2_cur;
            if (sif.m2_cache_hit && m2_cur != BLK_I) begin
                case (sif.bus_msg_in)
                    MSG_RD_MISS: begin
                        m2_state_d = BLK_S;
                        m2_hit_d   = 1'b1;
                        if (m2_cur == BLK_M) begin
                            m2_wb_d    = 1'b1;
                            m2_abort_d = 1'b1;
                            m2_data_d  = sif.m2_data_in;
                        end
                    end
                    MSG_WR_MISS: begin
                        m2_state_d = BLK_I;
                        m2_hit_d   = 1'b1;
                        if (m2_cur == BLK_M) begin
                            m2_wb_d    = 1'b1;
                            m2_abort_d = 1'b1;
                            m2_data_d  = sif.m2_data_in;
                        end
                    end
                    MSG_INV: begin
                        m2_state_d = BLK_I;
                        m2_hit_d   = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            m1_state_q <= BLK_I;
            m1_bus_q   <= MSG_NONE;
            m1_wb_q    <= 1'b0;
            m1_proc_q  <= '0;
            m2_state_q <= BLK_I;
            m2_wb_q    <= 1'b0;
            m2_abort_q <= 1'b0;
            m2_hit_q   <= 1'b0;
            m2_proc_q  <= '0;
            m2_data_q  <= '0;
        end else begin
            m1_state_q <= m1_state_d;
            m1_bus_q   <= m1_bus_d;
            m1_wb_q    <= m1_wb_d;
            m1_proc_q  <= m1_proc_d;
            m2_state_q <= m2_state_d;
            m2_wb_q    <= m2_wb_d;
            m2_abort_q <= m2_abort_d;
            m2_hit_q   <= m2_hit_d;
            m2_proc_q  <= m2_proc_d;
            m2_data_q  <= m2_data_d;
        end
    end

    assign sif.m1_state_out     = m1_state_q;
    assign sif.bus_msg_out      = m1_bus_q;
    assign sif.m1_writeback     = m1_wb_q;
    assign sif.m1_proc_out      = m1_proc_q;
    assign sif.m2_state_out     = m2_state_q;
    assign sif.m2_writeback     = m2_wb_q;
    assign sif.abort_mem_access = m2_abort_q;
    assign sif.m2_hit           = m2_hit_q;
    assign sif.m2_proc_out      = m2_proc_q;
    assign sif.m2_data_out      = m2_data_q;

`ifdef SNOOP_PROTOCOL_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = 1'b0;
        if (sif.m1_active &&
            (sif.m1_state_in == BLK_RSV || sif.cpu_action > ACT_WR_MISS))
            err_d = 1'b1;
        if (sif.m2_active &&
            (sif.m2_state_in == BLK_RSV || sif.bus_msg_in[2] ||
             (sif.m2_state_in == BLK_M && sif.bus_msg_in == MSG_INV)))
            err_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign sif.protocol_err = err_q;
`endif
endmodule

// File: tb/tb_snoop_state_machine.sv
// Directed self-checking bench for snoop_state_machine; expected values are hand-computed from the MSI tables.
module tb_snoop_state_machine;
    localparam int DATA_W = 8;
    localparam int PROC_W = 2;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_err;

    snoop_state_machine_if #(.DATA_W(DATA_W), .PROC_W(PROC_W)) sif ();

    snoop_state_machine #(.DATA_W(DATA_W), .PROC_W(PROC_W)) dut (
        .clock (clock),
        .reset (reset),
        .sif   (sif.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic m1_drive(input logic act, input logic [1:0] st, input logic [2:0] a,
                            input logic [PROC_W-1:0] p);
        sif.m1_active   = act;
        sif.m1_state_in = st;
        sif.cpu_action  = a;
        sif.m1_proc_in  = p;
    endtask

    task automatic m2_drive(input logic act, input logic hit, input logic [1:0] st,
                            input logic [2:0] msg, input logic [DATA_W-1:0] d,
                            input logic [PROC_W-1:0] p);
        sif.m2_active    = act;
        sif.m2_cache_hit = hit;
        sif.m2_state_in  = st;
        sif.bus_msg_in   = msg;
        sif.m2_data_in   = d;
        sif.m2_proc_in   = p;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_m1(input string tag, input logic [1:0] st, input logic [2:0] bus,
                            input logic wb, input logic [PROC_W-1:0] p);
        check_eq({tag, ".m1_state"}, 32'(sif.m1_state_out), 32'(st));
        check_eq({tag, ".bus"},      32'(sif.bus_msg_out),  32'(bus));
        check_eq({tag, ".m1_wb"},    32'(sif.m1_writeback), 32'(wb));
        check_eq({tag, ".m1_proc"},  32'(sif.m1_proc_out),  32'(p));
    endtask

    task automatic check_m2(input string tag, input logic [1:0] st, input logic wb,
                            input logic ab, input logic hit, input logic [DATA_W-1:0] d,
                            input logic [PROC_W-1:0] p);
        check_eq({tag, ".m2_state"}, 32'(sif.m2_state_out),     32'(st));
        check_eq({tag, ".m2_wb"},    32'(sif.m2_writeback),     32'(wb));
        check_eq({tag, ".abort"},    32'(sif.abort_mem_access), 32'(ab));
        check_eq({tag, ".m2_hit"},   32'(sif.m2_hit),           32'(hit));
        check_eq({tag, ".m2_data"},  32'(sif.m2_data_out),      32'(d));
        check_eq({tag, ".m2_proc"},  32'(sif.m2_proc_out),      32'(p));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        // Reset with both engines active and interesting inputs
        reset = 1'b0;
        m1_drive(1'b1, 2'd2, 3'b010, 2'd3);
        m2_drive(1'b1, 1'b1, 2'd2, 3'b001, 8'hA5, 2'd3);
        step();
        step();
        check_m1("rst", 2'd0, 3'd0, 1'b0, 2'd0);
        check_m2("rst", 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0);
`ifdef SNOOP_PROTOCOL_CHECK_EN
        check_eq("rst.perr", 32'(sif.protocol_err), 32'd0);
`endif

        reset = 1'b1;
        m2_drive(1'b0, 1'b0, 2'd0, 3'b000, 8'h00, 2'd0);

        // I + read miss
        m1_drive(1'b1, 2'd0, 3'b010, 2'd1);
        step();
        check_m1("i_rm", 2'd1, 3'd1, 1'b0, 2'd1);
        m1_drive(1'b0, 2'd2, 3'b100, 2'd2);
        step();
        check_m1("idle", 2'd1, 3'd0, 1'b0, 2'd1);

        m1_drive(1'b1, 2'd1, 3'b011, 2'd1);
        step();
        check_m1("s_wh", 2'd2, 3'd3, 1'b0, 2'd1);
        m1_drive(1'b1, 2'd2, 3'b010, 2'd2);
        step();
        check_m1("m_rm", 2'd1, 3'd1, 1'b1, 2'd2);

        // Boundary: read hit on Invalid acts as read miss
        m1_drive(1'b1, 2'd0, 3'b001, 2'd0);
        step();
        check_m1("i_rh", 2'd1, 3'd1, 1'b0, 2'd0);
        // Reserved state treated as Invalid: write hit -> write miss
        m1_drive(1'b1, 2'd3, 3'b011, 2'd3);
        step();
        check_m1("rsv_wh", 2'd2, 3'd2, 1'b0, 2'd3);
`ifdef SNOOP_PROTOCOL_CHECK_EN
        check_eq("rsv_wh.perr", 32'(sif.protocol_err), 32'd1);
`endif
        m1_drive(1'b1, 2'd2, 3'b100, 2'd1);
        step();
        check_m1("m_wm", 2'd2, 3'd2, 1'b1, 2'd1);
        m1_drive(1'b1, 2'd2, 3'b001, 2'd1);
        step();
        check_m1("m_rh", 2'd2, 3'd0, 1'b0, 2'd1);
        m1_drive(1'b1, 2'd1, 3'b000, 2'd2);
        step();
        check_m1("nop", 2'd1, 3'd0, 1'b0, 2'd2);
        m1_drive(1'b1, 2'd1, 3'b100, 2'd0);
        step();
        check_m1("s_wm", 2'd2, 3'd2, 1'b0, 2'd0);
        m1_drive(1'b0, 2'd0, 3'b000, 2'd0);

        // Snooper: Modified block, read miss
        m2_drive(1'b1, 1'b1, 2'd2, 3'b001, 8'h37, 2'd2);
        step();
        check_m2("m_rd", 2'd1, 1'b1, 1'b1, 1'b1, 8'h37, 2'd2);
        m2_drive(1'b1, 1'b1, 2'd1, 3'b010, 8'hFF, 2'd1);
        step();
        check_m2("s_wr", 2'd0, 1'b0, 1'b0, 1'b1, 8'h37, 2'd1);
        m2_drive(1'b1, 1'b0, 2'd1, 3'b010, 8'hFF, 2'd3);
        step();
        check_m2("nohit", 2'd1, 1'b0, 1'b0, 1'b0, 8'h37, 2'd3);
        m2_drive(1'b1, 1'b1, 2'd1, 3'b001, 8'h11, 2'd0);
        step();
        check_m2("s_rd", 2'd1, 1'b0, 1'b0, 1'b1, 8'h37, 2'd0);
        m2_drive(1'b0, 1'b1, 2'd2, 3'b001, 8'h99, 2'd3);
        step();
        check_m2("m2idle", 2'd1, 1'b0, 1'b0, 1'b0, 8'h37, 2'd0);
        m2_drive(1'b1, 1'b1, 2'd2, 3'b011, 8'h99, 2'd1);
        step();
        check_m2("m_inv", 2'd0, 1'b0, 1'b0, 1'b1, 8'h37, 2'd1);
`ifdef SNOOP_PROTOCOL_CHECK_EN
        check_eq("m_inv.perr", 32'(sif.protocol_err), 32'd1);
`endif
        m2_drive(1'b1, 1'b1, 2'd0, 3'b001, 8'h99, 2'd2);
        step();
        check_m2("i_rd", 2'd0, 1'b0, 1'b0, 1'b0, 8'h37, 2'd2);
        m2_drive(1'b1, 1'b1, 2'd2, 3'b000, 8'h99, 2'd2);
        step();
        check_m2("m_none", 2'd2, 1'b0, 1'b0, 1'b0, 8'h37, 2'd2);

        // Both engines in the same cycle
        m1_drive(1'b1, 2'd0, 3'b100, 2'd3);
        m2_drive(1'b1, 1'b1, 2'd2, 3'b010, 8'h5A, 2'd1);
        step();
        check_m1("sim", 2'd2, 3'd2, 1'b0, 2'd3);
        check_m2("sim", 2'd0, 1'b1, 1'b1, 1'b1, 8'h5A, 2'd1);

        // Reset during active evaluation discards it
        reset = 1'b0;
        m1_drive(1'b1, 2'd2, 3'b010, 2'd2);
        m2_drive(1'b1, 1'b1, 2'd2, 3'b001, 8'hC3, 2'd2);
        step();
        check_m1("midrst", 2'd0, 3'd0, 1'b0, 2'd0);
        check_m2("midrst", 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/snoop_state_machine.md
Name: snoop_state_machine

Overview:
- Coherence-controller core for one cache block slot in the snooping multiprocessor. Sits beside each processor cache.
- Combines two finite-state engines:
  - Requestor engine (M1): computes the next MSI state and bus message for a local CPU action.
  - Snooper engine (M2): computes the next MSI state, writeback and data-supply response for a bus message from another processor.
- Both engines are purely registered and share one clock.

Parameters:
- DATA_W, 8, width of the snooped data word.
- PROC_W, 2, width of the processor id.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- m1_active  in  1  requestor engine evaluates this cycle.
- cpu_action  in  3  001 read hit, 010 read miss, 011 write hit, 100 write miss; others are NOP.
- m1_state_in  in  2  current block state: 0 Invalid, 1 Shared, 2 Modified, 3 reserved.
- m1_proc_in  in  PROC_W  id of the requesting processor.
- m1_writeback  out  1  victim block must be written back.
- m1_state_out  out  2  next block state.
- bus_msg_out  out  3  bus message: 000 none, 001 RD_MISS, 010 WR_MISS, 011 INVALIDATE.
- m1_proc_out  out  PROC_W  latched requester id.
- m2_active  in  1  snooper engine evaluates this cycle.
- m2_cache_hit  in  1  snooping cache holds a matching tag.
- m2_state_in  in  2  snooping cache block state.
- m2_proc_in  in  PROC_W  snooping processor id.
- bus_msg_in  in  3  bus message, same encoding as bus_msg_out.
- m2_data_in  in  DATA_W  snooping cache block data.
- m2_writeback  out  1  snooper writes back its block.
- abort_mem_access  out  1  memory read suppressed; snooper supplies data.
- m2_hit  out  1  snooper holds valid copy.
- m2_state_out  out  2  snooper next state.
- m2_proc_out  out  PROC_W  latched snooper id.
- m2_data_out  out  DATA_W  data supplied to the bus.

Behaviour:
- Reset (reset=0 at a clock edge) clears all outputs to 0. Reset dominates active inputs. A reset mid-operation discards the pending evaluation.
- Latency: 1 cycle. Inputs are sampled at the edge where the active signal is 1; outputs are valid right after that edge.
- While an engine's active signal is 0:
  - Its pulse outputs (bus_msg_out, m1_writeback, m2_writeback, abort_mem_access, m2_hit) return to 0.
  - Its state, proc and data outputs hold their last values.
- M1 and M2 are independent and may be active in the same cycle.
- State 3 on any state input is treated as Invalid.
- M1 transitions (input state, action -> next state, bus message, writeback):
  - I, read/write hit: treated as the corresponding miss.
  - I, read miss -> S, RD_MISS, 0.
  - I, write miss -> M, WR_MISS, 0.
  - S, read hit -> S, none, 0.
  - S, read miss -> S, RD_MISS, 0.
  - S, write hit -> M, INVALIDATE, 0.
  - S, write miss -> M, WR_MISS, 0.
  - M, read hit or write hit -> M, none, 0.
  - M, read miss -> S, RD_MISS, 1.
  - M, write miss -> M, WR_MISS, 1.
  - NOP action -> state unchanged, none, 0.
- m1_proc_out is loaded from m1_proc_in whenever m1_active=1.
- M2 response when m2_cache_hit=1:
  - S, RD_MISS -> S, hit=1.
  - S, WR_MISS or INVALIDATE -> I, hit=1.
  - M, RD_MISS -> S, writeback=1, abort=1, hit=1, data_out=data_in.
  - M, WR_MISS -> I, writeback=1, abort=1, hit=1, data_out=data_in.
  - M, INVALIDATE -> I, writeback=0 (protocol-illegal case; no writeback).
  - I, any message -> I, hit=0.
  - Message 000: state unchanged, all pulse outputs 0.
- M2 when m2_cache_hit=0: m2_state_out=m2_state_in, all pulse outputs 0, data_out held.
- m2_proc_out is loaded from m2_proc_in whenever m2_active=1.

Optional Feature:
- Macro SNOOP_PROTOCOL_CHECK_EN.
- When defined: adds output protocol_err (1 bit, reset 0). It pulses 1 for one cycle after any active evaluation that sees state 3, an undefined cpu_action, bus_msg_in 1xx, or M2 receiving INVALIDATE in state M.
- When undefined: port absent. Those cases follow the rules above silently.

Test Plan:
- Reset: rst=0 with both active=1 for 2 cycles -> all outputs 0.
- M1 state I, action 010, proc 1 -> next cycle: state 1, bus 001, writeback 0, m1_proc_out 1. Active=0 the following cycle -> bus 000, state still 1.
- M1 state 1, action 011 -> state 2, bus 011. Then state 2, action 010 -> state 1, bus 001, writeback 1.
- M2 state 2, cache_hit 1, bus 001, data 0x37 -> state 1, writeback 1, abort 1, hit 1, data_out 0x37.
- M2 state 1, cache_hit 1, bus 010 -> state 0, hit 1, abort 0. Same stimulus with cache_hit 0 -> state 1, hit 0.
- Simultaneous: M1 (I, 100) and M2 (M, 010, data 0x5A) in the same cycle -> m1 state 2, bus 010; m2 state 0, writeback 1, data_out 0x5A.
